// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M definitions: funct3 encodings, FSM state encoding and datapath width.
// The execute-stage ALU and the decoder import this package as well.
package muldiv_unit_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Returns {op_a is signed, op_b is signed}. MUL only keeps the low half,
  // which is the same whether the operands are read as signed or unsigned.
  function automatic logic [1:0] op_signed(input logic [2:0] f3);
    logic [1:0] sgn;
    sgn = 2'b00;
    case (f3)
      F3_MULH, F3_DIV, F3_REM:             sgn = 2'b11;
      F3_MULHSU:                           sgn = 2'b10;
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU:  sgn = 2'b00;
      default:                             sgn = 2'b00;
    endcase
    return sgn;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one result bit per cycle through a single shared 2*XLEN accumulator.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = RV_XLEN,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0]   LAST_CNT = CW'(ITER - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opd;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_neg;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  logic [1:0]        w_sgn;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_neg;
  logic              w_div_zero;
  logic              w_ovf;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_fix;

  // Acceptance decode: magnitudes, result sign and the divide special cases.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_sgn         = op_signed(funct3);
    w_a_neg       = w_sgn[1] & op_a[XLEN-1];
    w_b_neg       = w_sgn[0] & op_b[XLEN-1];
    w_a_mag       = w_a_neg ? ('0 - op_a) : op_a;
    w_b_mag       = w_b_neg ? ('0 - op_b) : op_b;
    // Remainder follows the dividend; quotient and product follow both operands.
    w_neg         = (funct3[2] & funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero    = funct3[2] && (op_b == '0);
    w_ovf         = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (op_a == MIN_NEG) && (op_b == '1);
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = funct3[1] ? op_a : '1;
    else if (w_ovf)
      w_special_res = funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration of each algorithm; r_opd holds the multiplicand or the divisor.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    // Partial remainder is < 2*divisor, so XLEN+1 bits hold it and the sign bit is the borrow.
    w_div_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opd};
    w_div_next = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                  : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    w_prod = r_neg ? ('0 - r_acc) : r_acc;
    w_fix  = '0;
    if (!r_f3[2]) begin
      w_fix = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end else begin
      w_fix = r_f3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
      if (r_neg) w_fix = '0 - w_fix;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opd    <= '0;
      r_f3     <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else if (kill) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_f3  <= funct3;
            r_cnt <= '0;
            if (w_div_zero || w_ovf) begin
              r_result <= w_special_res;
              r_rd_out <= rd_in;
              r_state  <= ST_DONE;
            end else begin
              r_rd    <= rd_in;
              r_neg   <= w_neg;
              r_acc   <= {{XLEN{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
              r_opd   <= funct3[2] ? w_b_mag : w_a_mag;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_acc <= r_f3[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_result <= w_fix;
          r_rd_out <= r_rd;
          r_state  <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == ST_CALC) || (r_state == ST_FIX);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of RV32M ops with hand-computed results,
// then hand-written kill, reset and start-while-busy sequences.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one op, holds start until done (as the upstream stage does), and checks
  // result, destination, done latency and number of busy cycles.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int cyc;
    int busy_cnt;
    logic got;
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    cyc = 0; busy_cnt = 0; got = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got   = 1'b1;
        start = 1'b0;
        check({name, " busy_at_done"}, 32'(busy), 32'd0);
        check({name, " result"}, result, exp);
        check({name, " rd_out"}, 32'(rd_out), 32'(rd));
      end else begin
        busy_cnt += int'(busy);
      end
    end
    start = 1'b0;
    check({name, " done_seen"}, 32'(got), 32'd1);
    check({name, " latency"}, 32'(cyc), 32'(lat));
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
    last_res = exp;
    last_rd  = rd;
  endtask

  initial begin
    int n_done;
    int n_busy;
    int first_done;

    vecs = '{
      '{F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34},
      '{F3_MULH,   32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 34},
      '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 34},
      '{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 34},
      '{F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 34},
      '{F3_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 34},
      '{F3_DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       34},
      '{F3_REMU,   32'd100,      32'd7,        5'd8,  32'd2,        34},
      '{F3_DIVU,   32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1},
      '{F3_REMU,   32'd5,        32'd0,        5'd11, 32'd5,        1},
      '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1},
      '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1},
      '{F3_MULH,   32'h80000000, 32'h7FFFFFFF, 5'd14, 32'hC0000000, 34},
      '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'hFFFFFFFF, 34},
      '{F3_DIV,    32'd7,        32'hFFFFFFFE, 5'd16, 32'hFFFFFFFD, 34},
      '{F3_REM,    32'd7,        32'hFFFFFFFE, 5'd17, 32'd1,        34},
      '{F3_REMU,   32'hFFFFFFFF, 32'h80000000, 5'd18, 32'h7FFFFFFF, 34},
      '{F3_DIVU,   32'hFFFFFFFF, 32'd1,        5'd19, 32'hFFFFFFFF, 34},
      '{F3_DIV,    32'h80000000, 32'd1,        5'd0,  32'h80000000, 34},
      '{F3_REM,    32'hFFFFFFF7, 32'd0,        5'd31, 32'hFFFFFFF7, 1},
      '{F3_MUL,    32'h12345678, 32'd0,        5'd20, 32'd0,        34},
      '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 32'd0,        34}
    };

    rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    #1;
    check("reset busy",   32'(busy),   32'd0);
    check("reset done",   32'(done),   32'd0);
    check("reset result", result,      32'd0);
    check("reset rd_out", 32'(rd_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
             vecs[i].rd, vecs[i].exp, vecs[i].lat);

    // Kill during cycle 10 of a DIV: no done, busy drops, outputs keep the last result.
    @(negedge clk);
    funct3 = F3_DIV; op_a = 32'hFFFFFFF9; op_b = 32'd2; rd_in = 5'd3; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    check("kill busy_before", 32'(busy), 32'd1);
    kill = 1'b1; start = 1'b0;
    n_done = 0; n_busy = 0;
    for (int c = 11; c <= 50; c++) begin
      @(negedge clk);
      if (c == 11) kill = 1'b0;
      if (done) n_done++;
      if (c >= 12 && busy) n_busy++;
    end
    check("kill no_done",   32'(n_done), 32'd0);
    check("kill busy_low",  32'(n_busy), 32'd0);
    check("kill result",    result,      last_res);
    check("kill rd_out",    32'(rd_out), 32'(last_rd));
    run_op("after_kill mul", F3_MUL, 32'd3, 32'd4, 5'd9, 32'd12, 34);

    // kill together with start in IDLE discards the request.
    @(negedge clk);
    funct3 = F3_DIVU; op_a = 32'd9; op_b = 32'd0; rd_in = 5'd2; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    n_done = 0; n_busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check("idle_kill no_done", 32'(n_done), 32'd0);
    check("idle_kill no_busy", 32'(n_busy), 32'd0);
    check("idle_kill result",  result,      32'd12);

    // Reset in cycle 20 of a MUL with start held high.
    @(negedge clk);
    funct3 = F3_MUL; op_a = 32'h1234; op_b = 32'h10; rd_in = 5'd7; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) @(negedge clk);
    check("rst busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst busy",   32'(busy),   32'd0);
    check("rst done",   32'(done),   32'd0);
    check("rst result", result,      32'd0);
    check("rst rd_out", 32'(rd_out), 32'd0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0; n_busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check("rst no_done_after", 32'(n_done), 32'd0);
    check("rst no_busy_after", 32'(n_busy), 32'd0);
    run_op("after_rst mul", F3_MUL, 32'h1234, 32'h10, 5'd7, 32'h12340, 34);

    // start pulsed while busy (a divide-by-zero that would finish at once) is ignored.
    @(negedge clk);
    funct3 = F3_MUL; op_a = 32'd5; op_b = 32'd6; rd_in = 5'd9; start = 1'b1;
    @(posedge clk);
    n_done = 0; first_done = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) begin
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd0; rd_in = 5'd1;
      end
      if (c == 6) start = 1'b0;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          first_done = c;
          check("busy_start result", result,      32'd30);
          check("busy_start rd_out", 32'(rd_out), 32'd9);
        end
      end
    end
    check("busy_start single_done", 32'(n_done),     32'd1);
    check("busy_start latency",     32'(first_done), 32'd34);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the two register-file read operands (rs1/rs2 data) and produces a 32-bit result plus destination index for the register-file write port (bus_w / rw / reg_wr).
- Holds the core through a start/busy/done handshake; one operation in flight at a time.
- Radix-2: shift-add multiply, restoring divide, one result bit per cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count in CALC; must equal XLEN.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  32  rs1 value (register-file read port A)
- op_b  input  32  rs2 value (register-file read port B)
- rd_in  input  5  destination register index
- kill  input  1  synchronous abort (pipeline flush)
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  one-cycle pulse; result and rd_out valid
- result  output  32  registered result
- rd_out  output  5  registered destination index

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result=0, rd_out=0; all internal registers cleared. A reset mid-operation aborts it; no done after release.
- States:
  - IDLE: start=1 latches funct3, rd_in and operands, then goes to CALC. Special cases go to DONE instead (see below).
  - CALC: ITER cycles, counter from 0 to 31. Goes to FIX when the counter reaches 31.
  - FIX: sign correction and high/low selection; loads result. Goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. Returns to IDLE. start is not accepted in DONE.
- Latency:
  - start sampled at edge 0.
  - Normal ops: CALC occupies cycles 1..32, FIX cycle 33, done high in cycle 34.
  - Special cases: done high in cycle 1.
- busy is 1 in CALC and FIX, 0 in IDLE and DONE.
- result and rd_out hold their last value until the next done; they are not cleared on return to IDLE.
- Operand handling: signed operands (MULH, DIV, REM: both; MULHSU: op_a only) are converted to magnitudes at acceptance; result sign is applied in FIX.
- Multiply: 64-bit product. MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32] of the correctly signed product.
- Divide: truncation toward zero; remainder takes the sign of the dividend.
- Special cases (detected in IDLE, no CALC):
  - Divisor 0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU remainder = op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- start while busy or in DONE: ignored, no queuing; the upstream stage holds start until it sees done.
- kill: state goes to IDLE at the next edge, no done, busy=0 the following cycle; result/rd_out unchanged. kill in IDLE with start=1: start is discarded. kill has priority over every transition.
- rd_out=0: done still pulses; the register file discards writes to x0, so no special handling here.
- Writeback hookup: reg_wr = done, rw = rd_out, bus_w = result.

Decomposition:
- Shared package (with ALU/decoder): RV32M funct3 localparams, FSM state encoding (IDLE, CALC, FIX, DONE; 2 bits), XLEN.
- No sub-module: single FSM plus one shared 64-bit accumulator/shift datapath used by both multiply and divide. Target 150-250 lines.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> done in cycle 34, result 0xFFFFFFEB, rd_out = rd_in (5), busy high cycles 1..33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF with done in cycle 1; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1; REM same operands -> 0.
- kill asserted in cycle 10 of a DIV -> no done pulse, busy=0 from cycle 12, result unchanged; a new MUL 3 x 4 accepted next -> 12.
- rst_n low in cycle 20 of a MUL, start held high throughout -> outputs 0 immediately, no done after release. start re-asserted after release -> accepted normally. start pulsed while busy -> ignored, single done.
